// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matmul datapath among NREQ requesters.
// Optional watchdog enabled by defining MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS  = 13,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_in,
  input  logic [2*NREQ-1:0]         op_in,
  input  logic [NREQ*D_WIDTH-1:0]   a_in,
  input  logic [NREQ*D_WIDTH-1:0]   b_in,
  input  logic [NREQ*16-1:0]        sin_in,
  input  logic [NREQ*16-1:0]        cos_in,
  output logic [NREQ-1:0]           gnt_out,
  output logic [NREQ-1:0]           rsp_valid_out,
  output logic [D_WIDTH-1:0]        rsp_a_out,
  output logic [D_WIDTH-1:0]        rsp_b_out,
  output logic                      rsp_err_out,
  output logic                      busy_out,
  output logic                      mm_start,
  output logic [1:0]                mm_op,
  output logic [D_WIDTH-1:0]        mm_a,
  output logic [D_WIDTH-1:0]        mm_b,
  output logic [15:0]               mm_sin,
  output logic [15:0]               mm_cos,
  input  logic                      mm_done,
  input  logic [D_WIDTH-1:0]        mm_a_res,
  input  logic [D_WIDTH-1:0]        mm_b_res
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Q_BITS is informational; it only takes part in the legality check.
  if (NREQ < 2 || NREQ > 4 || Q_BITS >= D_WIDTH || TIMEOUT < 1) begin : g_param_check
    $error("matmul_arbiter: illegal parameter combination");
  end

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [NREQ-1:0]    mask_q, mask_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [D_WIDTH-1:0] rsp_a_q, rsp_a_d;
  logic [D_WIDTH-1:0] rsp_b_q, rsp_b_d;
  logic               start_q, start_d;
  logic [1:0]         op_q, op_d;
  logic [D_WIDTH-1:0] mma_q, mma_d;
  logic [D_WIDTH-1:0] mmb_q, mmb_d;
  logic [15:0]        sin_q, sin_d;
  logic [15:0]        cos_q, cos_d;

  logic [NREQ-1:0]    eff;
  logic [IW-1:0]      sel;
  logic               found;
  logic [NREQ-1:0]    sel_oh;
  logic [NREQ-1:0]    win_oh;
  int unsigned        idx;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          expired;
  assign expired     = (cnt_q >= CW'(TIMEOUT));
  assign rsp_err_out = err_q;
`else
  assign rsp_err_out = 1'b0;
`endif

  // First unmasked request at or above the pointer, wrapping at NREQ.
  always_comb begin
    eff   = req_in & ~mask_q;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && eff[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign sel_oh = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    mask_d      = mask_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    start_d     = 1'b0;
    op_d        = op_q;
    mma_d       = mma_q;
    mmb_d       = mmb_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = sel;
          gnt_d   = sel_oh;
          mask_d  = mask_q | sel_oh;
          start_d = 1'b1;
          op_d    = op_in[sel*2 +: 2];
          mma_d   = a_in[sel*D_WIDTH +: D_WIDTH];
          mmb_d   = b_in[sel*D_WIDTH +: D_WIDTH];
          sin_d   = sin_in[sel*16 +: 16];
          cos_d   = cos_in[sel*16 +: 16];
          state_d = RUN;
`ifdef MATMUL_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
`ifdef MATMUL_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A done arriving on the expiry cycle takes precedence over the timeout.
        if (mm_done) begin
          rsp_a_d     = mm_a_res;
          rsp_b_d     = mm_b_res;
          rsp_valid_d = win_oh;
          state_d     = RESP;
`ifdef MATMUL_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (expired) begin
          rsp_a_d     = '0;
          rsp_b_d     = '0;
          rsp_valid_d = win_oh;
          err_d       = 1'b1;
          state_d     = RESP;
`endif
        end
      end
      RESP: begin
        mask_d  = mask_q & ~win_oh;
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      mask_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      start_q     <= 1'b0;
      op_q        <= '0;
      mma_q       <= '0;
      mmb_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      mask_q      <= mask_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      start_q     <= start_d;
      op_q        <= op_d;
      mma_q       <= mma_d;
      mmb_q       <= mmb_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt_out       = gnt_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_a_out     = rsp_a_q;
  assign rsp_b_out     = rsp_b_q;
  assign busy_out      = (state_q != IDLE);
  assign mm_start      = start_q;
  assign mm_op         = op_q;
  assign mm_a          = mma_q;
  assign mm_b          = mmb_q;
  assign mm_sin        = sin_q;
  assign mm_cos        = cos_q;

endmodule
